// File: rtl/object_pkg.sv
// rtl/object_pkg.sv - shared sprite geometry, colour width and sequencer state encoding
package object_pkg;

    localparam int OBJ_SIDE   = 16;
    localparam int OBJ_PIXELS = 256;
    localparam int COLOR_W    = 24;
    localparam int SIDE_W     = $clog2(OBJ_SIDE);
    localparam int ADDR_W     = $clog2(OBJ_PIXELS);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/object_drawer.sv
// rtl/object_drawer.sv - scans the 16x16 sprite ROM and emits clipped, keyed plot strobes to the VGA adapter
module object_drawer
    import object_pkg::*;
#(
    parameter int                 X_W         = 8,
    parameter int                 Y_W         = 7,
    parameter int                 X_MAX       = 160,
    parameter int                 Y_MAX       = 120,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 24'h000000
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               erase,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [COLOR_W-1:0] bg_colour,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_q,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_colour,
    output logic               vga_plot
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OBJ_PIXELS - 1);
    localparam logic [X_W:0]      X_LIM     = X_MAX[X_W:0];
    localparam logic [Y_W:0]      Y_LIM     = Y_MAX[Y_W:0];

    state_t state, state_n;

    logic [X_W-1:0]     cap_x;
    logic [Y_W-1:0]     cap_y;
    logic               cap_erase;
    logic [COLOR_W-1:0] cap_bg;
    logic               flush_cnt;

    // Tag for the address currently being read by the ROM; lines up with rom_q.
    logic [ADDR_W-1:0]  tag_addr;
    logic               tag_valid;

    logic [SIDE_W-1:0]  tag_row;
    logic [SIDE_W-1:0]  tag_col;
    logic [X_W:0]       px;
    logic [Y_W:0]       py;
    logic               visible;

    assign tag_row = tag_addr[ADDR_W-1:SIDE_W];
    assign tag_col = tag_addr[SIDE_W-1:0];

    // One extra bit so an origin near the edge overflows into a clipped value, never a wrap.
    assign px = {1'b0, cap_x} + {{(X_W + 1 - SIDE_W){1'b0}}, tag_col};
    assign py = {1'b0, cap_y} + {{(Y_W + 1 - SIDE_W){1'b0}}, tag_row};

    assign visible = (px < X_LIM) && (py < Y_LIM) && (rom_q != TRANSPARENT);

    assign busy = (state == SCAN) || (state == FLUSH);
    assign done = (state == DONE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SCAN;
            SCAN:    if (rom_addr == LAST_ADDR) state_n = FLUSH;
            FLUSH:   if (flush_cnt) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cap_x      <= '0;
            cap_y      <= '0;
            cap_erase  <= 1'b0;
            cap_bg     <= '0;
            rom_addr   <= '0;
            flush_cnt  <= 1'b0;
            tag_addr   <= '0;
            tag_valid  <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cap_x     <= x0;
                cap_y     <= y0;
                cap_erase <= erase;
                cap_bg    <= bg_colour;
                rom_addr  <= '0;
            end else if (state == SCAN && rom_addr != LAST_ADDR) begin
                rom_addr <= rom_addr + 1'b1;
            end

            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;

            tag_addr  <= rom_addr;
            tag_valid <= (state == SCAN);

            vga_x      <= px[X_W-1:0];
            vga_y      <= py[Y_W-1:0];
            vga_colour <= cap_erase ? cap_bg : rom_q;
            vga_plot   <= tag_valid && visible;
        end
    end

endmodule

// File: tb/tb_object_drawer.sv
// tb/tb_object_drawer.sv - self-checking bench for object_drawer against a per-pixel reference model
module tb_object_drawer;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic        erase = 1'b0;
    logic [7:0]  x0 = '0;
    logic [6:0]  y0 = '0;
    logic [23:0] bg_colour = '0;
    logic        busy;
    logic        done;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [23:0] vga_colour;
    logic        vga_plot;

    logic [23:0] mem [256];
    logic [7:0]  rom_addr_q = '0;

    int tests = 0;
    int failed = 0;

    object_drawer dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .erase      (erase),
        .x0         (x0),
        .y0         (y0),
        .bg_colour  (bg_colour),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;

    // Sprite ROM: registered address, combinational read.
    always @(posedge clock) rom_addr_q <= rom_addr;
    assign rom_q = mem[rom_addr_q];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_solid(input logic [23:0] c);
        for (int n = 0; n < 256; n++) mem[n] = c;
    endtask

    task automatic fill_checker();
        for (int n = 0; n < 256; n++)
            mem[n] = (((n % 16) + (n / 16)) % 2 == 1) ? 24'h000000 : 24'($urandom_range(1, 24'hFFFFFF));
    endtask

    task automatic fill_random();
        for (int n = 0; n < 256; n++)
            mem[n] = ($urandom_range(0, 3) == 0) ? 24'h000000 : 24'($urandom_range(1, 24'hFFFFFF));
    endtask

    function automatic bit pix_vis(input int n, input int xo, input int yo);
        return ((xo + n % 16) < 160) && ((yo + n / 16) < 120) && (mem[n] != 24'h000000);
    endfunction

    task automatic run_sprite(input int xo, input int yo, input bit er, input logic [23:0] bg,
                              input int poke_at, input int rst_at, input int want,
                              output int first_xy, output int last_xy);
        int  plots;
        int  exp_plots;
        int  n;
        bit  aborted;
        bit  ep;
        exp_plots = 0;
        for (int k = 0; k < 256; k++) if (pix_vis(k, xo, yo)) exp_plots++;
        plots    = 0;
        aborted  = 1'b0;
        first_xy = -1;
        last_xy  = -1;

        @(negedge clock);
        x0 = xo[7:0]; y0 = yo[6:0]; erase = er; bg_colour = bg; start = 1'b1;
        for (int c = 1; c <= 262; c++) begin
            @(negedge clock);
            if (c == 1) start = 1'b0;
            if (c == poke_at + 1) start = 1'b0;
            if (c == poke_at) begin
                start = 1'b1; x0 = ~x0; y0 = ~y0; erase = ~er; bg_colour = ~bg;
            end
            if (c == rst_at + 4) resetn = 1'b1;

            n  = c - 3;
            ep = !aborted && n >= 0 && n < 256 && pix_vis(n, xo, yo);
            check("busy", 32'(busy), 32'(!aborted && c <= 258));
            check("done", 32'(done), 32'(!aborted && c == 259));
            check("plot", 32'(vga_plot), 32'(ep));
            if (ep) begin
                check("vga_x", 32'(vga_x), 32'(xo + n % 16));
                check("vga_y", 32'(vga_y), 32'(yo + n / 16));
                check("vga_colour", 32'(vga_colour), 32'(er ? bg : mem[n]));
            end
            if (vga_plot === 1'b1) begin
                plots++;
                if (first_xy < 0) first_xy = int'(vga_x) * 256 + int'(vga_y);
                last_xy = int'(vga_x) * 256 + int'(vga_y);
            end

            if (c == rst_at) begin
                resetn  = 1'b0;
                aborted = 1'b1;
                #1;
                check("rst_plot", 32'(vga_plot), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_addr", 32'(rom_addr), 32'd0);
                check("rst_colour", 32'(vga_colour), 32'd0);
            end
        end
        if (!aborted) check("plot_count_model", 32'(plots), 32'(exp_plots));
        if (want >= 0) check("plot_count", 32'(plots), 32'(want));
    endtask

    initial begin
        int fxy;
        int lxy;
        fill_solid(24'h000000);

        #1 resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_vga_x", 32'(vga_x), 32'd0);
        check("reset_vga_y", 32'(vga_y), 32'd0);
        check("reset_vga_colour", 32'(vga_colour), 32'd0);
        check("reset_vga_plot", 32'(vga_plot), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clock);

        fill_solid(24'hFF0000);
        run_sprite(10, 20, 1'b0, 24'h0, -10, -10, 256, fxy, lxy);
        check("first_plot_xy", 32'(fxy), 32'(10 * 256 + 20));
        check("last_plot_xy", 32'(lxy), 32'(25 * 256 + 35));

        fill_checker();
        run_sprite(10, 20, 1'b0, 24'h0, -10, -10, 128, fxy, lxy);
        run_sprite(10, 20, 1'b1, 24'h00FF00, -10, -10, 128, fxy, lxy);

        fill_solid(24'h123456);
        run_sprite(150, 110, 1'b0, 24'h0, -10, -10, 100, fxy, lxy);
        check("clip_last_xy", 32'(lxy), 32'(159 * 256 + 119));

        fill_random();
        run_sprite(40, 30, 1'b0, 24'hABCDEF, 50, -10, -1, fxy, lxy);
        run_sprite(3, 7, 1'b1, 24'h0F0F0F, 259, -10, -1, fxy, lxy);
        run_sprite(60, 50, 1'b0, 24'h0, 1, -10, -1, fxy, lxy);

        fill_solid(24'h0000FF);
        run_sprite(20, 10, 1'b0, 24'h0, -10, 100, -1, fxy, lxy);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("post_reset_done", 32'(done), 32'd0);
            check("post_reset_busy", 32'(busy), 32'd0);
        end
        run_sprite(20, 10, 1'b0, 24'h0, -10, -10, 256, fxy, lxy);

        for (int r = 0; r < 5; r++) begin
            fill_random();
            run_sprite(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                       1'($urandom_range(0, 1)), 24'($urandom), -10, -10, -1, fxy, lxy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
